riscv_decode_stage: RTL and testbench
=====================================

# riscv_decode_stage

Registered instruction decoder between the fetch and execute stages of the RISC-V core. Accepts one 32-bit RV32I instruction per handshake, decodes it into the 5-bit ALU operator code, operand selects, immediate and control strobes consumed by the execute-stage ALU, and holds the result in a single valid/ready pipeline register. Illegal encodings are flagged rather than dropped.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value of pc_o after reset.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- instr_i  in  32  instruction word.
- pc_i  in  32  address of instr_i.
- in_valid_i  in  1  instr_i/pc_i valid.
- in_ready_o  out  1  stage can accept a beat.
- flush_i  in  1  discard the held and incoming beats.
- out_valid_o  out  1  decoded beat valid.
- out_ready_i  in  1  execute stage accepts the beat.
- pc_o  out  32  registered pc_i.
- alu_op_o  out  5  ALU operator code.
- src_a_sel_o  out  2  operand A: 0 rs1, 1 pc, 2 zero.
- src_b_sel_o  out  2  operand B: 0 rs2, 1 imm, 2 constant 4.
- imm_o  out  32  sign-extended immediate (I/S/B/U/J per opcode, else 0).
- rs1_o, rs2_o, rd_o  out  5 each  register addresses from instr[19:15], [24:20], [11:7].
- wb_en_o  out  1  rd write-back enable (forced 0 when rd = 0).
- mem_req_o, mem_we_o  out  1 each  load/store request, store flag.
- mem_size_o  out  3  funct3 of load/store.
- branch_o, jal_o, jalr_o  out  1 each  control-flow type.
- illegal_o  out  1  illegal instruction.

## Operation
- ALU codes: ADD 00000, SUB 01000, SLL 00001, LTS 00010, LTU 00011, XOR 00100, SRL 00101, SRA 01101, OR 00110, AND 00111; compare: EQ 11000, NE 11001, LTS_F 11100, GES 11101, LTU_F 11110, GEU 11111.
- OP (0110011): alu_op = {1'b0, funct7[5], funct3}; A rs1, B rs2, wb.
- OP-IMM (0010011): alu_op = {1'b0, funct3==101 ? funct7[5] : 1'b0, funct3}; A rs1, B imm, wb.
- BRANCH (1100011): alu_op = {2'b11, funct3}; A rs1, B rs2, branch_o, B-imm.
- LOAD/STORE (0000011/0100011): ADD, A rs1, B imm, mem_req; store sets mem_we, wb_en=0.
- LUI: ADD, A zero, B U-imm. AUIPC: ADD, A pc, B U-imm. JAL/JALR: ADD, A pc, B 4, wb, jal_o/jalr_o, J-/I-imm.
- MISC-MEM (0001111): legal NOP, all strobes 0.
- Illegal: instr[1:0] != 11; unknown opcode; SYSTEM; OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101; OP-IMM shift with funct7 other than 0000000 (SLLI/SRLI) or 0100000 (SRAI); load funct3 011/110/111; store funct3 > 010; branch funct3 010/011; JALR funct3 != 000. Illegal beat: illegal_o=1, alu_op ADD, wb_en/mem_req/mem_we/branch/jal/jalr all 0.

## Timing
- Reset: out_valid_o=0, pc_o=RESET_PC, all other outputs 0; in_ready_o=1.
- in_ready_o = !out_valid_o || out_ready_i (combinational).
- Beat accepted when in_valid_i && in_ready_o; decoded outputs valid the next cycle (latency 1, throughput 1/cycle).
- out_valid_o && !out_ready_i: all outputs held stable, no new beat accepted.
- Consume and accept same cycle: register reloads, out_valid_o stays 1.
- flush_i: out_valid_o=0 next cycle, takes priority over accept; in_ready_o forced 1, incoming beat discarded.
- Reset asserted mid-operation: immediate return to reset values regardless of clock.

## Test plan
- add x3,x1,x2 (0x002081B3) -> next cycle alu_op 00000, src_a 0, src_b 0, rd 3, wb_en 1, illegal 0.
- sub/srai/bgeu (0x40208133, 0x4020D093, 0x0020F463) -> alu_op 01000, 01101 with imm 2, 11111 with imm 8 and branch_o 1.
- jal x1,-4 (0xFFDFF0EF) -> alu_op ADD, src_a 1, src_b 2, imm 0xFFFFFFFC, jal_o 1; out_ready_i low 3 cycles -> outputs held, in_ready_o 0.
- 0x00000000 and funct7=0000001 OP -> illegal_o 1, all strobes 0.
- Back-to-back 8 beats with out_ready_i=1 -> 8 consecutive valid outputs, pc order preserved.
- flush_i while holding a beat with in_valid_i=1 -> out_valid_o 0 next cycle, incoming beat never emitted; rst_i pulse mid-stream -> out_valid_o 0 immediately.

Source files
------------

// File: rtl/riscv_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_decode_stage
//  Description : RV32I instruction decoder with a single valid/ready output
//                register. Produces ALU operator, operand selects, immediate
//                and control strobes for the execute stage. Illegal encodings
//                are passed through with illegal_o set and all side-effect
//                strobes cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] pc_o,
    output logic [4:0]  alu_op_o,
    output logic [1:0]  src_a_sel_o,
    output logic [1:0]  src_b_sel_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        wb_en_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic        branch_o,
    output logic        jal_o,
    output logic        jalr_o,
    output logic        illegal_o
);

    // ------------------------------------------------------------------------
    // Encoding constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP       = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] c_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] c_OPC_MISC_MEM = 7'b0001111;

    localparam logic [6:0] c_F7_BASE      = 7'b0000000;
    localparam logic [6:0] c_F7_ALT       = 7'b0100000;

    localparam logic [4:0] c_ALU_ADD      = 5'b00000;

    localparam logic [1:0] c_SRC_A_RS1    = 2'd0;
    localparam logic [1:0] c_SRC_A_PC     = 2'd1;
    localparam logic [1:0] c_SRC_A_ZERO   = 2'd2;
    localparam logic [1:0] c_SRC_B_RS2    = 2'd0;
    localparam logic [1:0] c_SRC_B_IMM    = 2'd1;
    localparam logic [1:0] c_SRC_B_FOUR   = 2'd2;

    // ------------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_sh;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_rd     = instr_i[11:7];

    assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u  = {instr_i[31:12], 12'b0};
    assign w_imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};
    // Shift-immediates carry only the shift amount; funct7 selects the shift
    // type and must not leak into the operand.
    assign w_imm_sh = {27'b0, instr_i[24:20]};

    // ------------------------------------------------------------------------
    // Decoded (pre-register) values
    // ------------------------------------------------------------------------
    logic [4:0]  w_alu_op;
    logic [1:0]  w_src_a;
    logic [1:0]  w_src_b;
    logic [31:0] w_imm;
    logic        w_wb;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [2:0]  w_mem_size;
    logic        w_branch;
    logic        w_jal;
    logic        w_jalr;
    logic        w_illegal;

    // Combinational RV32I decode; an illegal result clears every side effect.
    always_comb begin
        w_alu_op   = c_ALU_ADD;
        w_src_a    = c_SRC_A_RS1;
        w_src_b    = c_SRC_B_RS2;
        w_imm      = 32'b0;
        w_wb       = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_size = 3'b0;
        w_branch   = 1'b0;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_illegal  = 1'b0;

        if (instr_i[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                c_OPC_OP: begin
                    w_alu_op = {1'b0, w_funct7[5], w_funct3};
                    w_wb     = 1'b1;
                    if (w_funct7 == c_F7_BASE) begin
                        w_illegal = 1'b0;
                    end else if ((w_funct7 == c_F7_ALT) &&
                                 ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                        w_illegal = 1'b0;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                c_OPC_OP_IMM: begin
                    w_alu_op = {1'b0, (w_funct3 == 3'b101) ? w_funct7[5] : 1'b0, w_funct3};
                    w_src_b  = c_SRC_B_IMM;
                    w_wb     = 1'b1;
                    if (w_funct3 == 3'b001) begin
                        w_imm     = w_imm_sh;
                        w_illegal = (w_funct7 != c_F7_BASE);
                    end else if (w_funct3 == 3'b101) begin
                        w_imm     = w_imm_sh;
                        w_illegal = (w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT);
                    end else begin
                        w_imm     = w_imm_i;
                    end
                end
                c_OPC_BRANCH: begin
                    w_alu_op  = {2'b11, w_funct3};
                    w_imm     = w_imm_b;
                    w_branch  = 1'b1;
                    w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                end
                c_OPC_LOAD: begin
                    w_src_b    = c_SRC_B_IMM;
                    w_imm      = w_imm_i;
                    w_wb       = 1'b1;
                    w_mem_req  = 1'b1;
                    w_mem_size = w_funct3;
                    w_illegal  = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                                 (w_funct3 == 3'b111);
                end
                c_OPC_STORE: begin
                    w_src_b    = c_SRC_B_IMM;
                    w_imm      = w_imm_s;
                    w_mem_req  = 1'b1;
                    w_mem_we   = 1'b1;
                    w_mem_size = w_funct3;
                    w_illegal  = (w_funct3 > 3'b010);
                end
                c_OPC_LUI: begin
                    w_src_a = c_SRC_A_ZERO;
                    w_src_b = c_SRC_B_IMM;
                    w_imm   = w_imm_u;
                    w_wb    = 1'b1;
                end
                c_OPC_AUIPC: begin
                    w_src_a = c_SRC_A_PC;
                    w_src_b = c_SRC_B_IMM;
                    w_imm   = w_imm_u;
                    w_wb    = 1'b1;
                end
                c_OPC_JAL: begin
                    w_src_a = c_SRC_A_PC;
                    w_src_b = c_SRC_B_FOUR;
                    w_imm   = w_imm_j;
                    w_wb    = 1'b1;
                    w_jal   = 1'b1;
                end
                c_OPC_JALR: begin
                    w_src_a   = c_SRC_A_PC;
                    w_src_b   = c_SRC_B_FOUR;
                    w_imm     = w_imm_i;
                    w_wb      = 1'b1;
                    w_jalr    = 1'b1;
                    w_illegal = (w_funct3 != 3'b000);
                end
                c_OPC_MISC_MEM: begin
                    // FENCE is a no-op in this in-order core.
                    w_illegal = 1'b0;
                end
                default: begin
                    // SYSTEM and every unassigned opcode.
                    w_illegal = 1'b1;
                end
            endcase
        end

        if (w_illegal) begin
            w_alu_op   = c_ALU_ADD;
            w_src_a    = c_SRC_A_RS1;
            w_src_b    = c_SRC_B_RS2;
            w_imm      = 32'b0;
            w_wb       = 1'b0;
            w_mem_req  = 1'b0;
            w_mem_we   = 1'b0;
            w_mem_size = 3'b0;
            w_branch   = 1'b0;
            w_jal      = 1'b0;
            w_jalr     = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline register and handshake
    // ------------------------------------------------------------------------
    logic        r_valid;
    logic [31:0] r_pc;
    logic [4:0]  r_alu_op;
    logic [1:0]  r_src_a;
    logic [1:0]  r_src_b;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_wb_en;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [2:0]  r_mem_size;
    logic        r_branch;
    logic        r_jal;
    logic        r_jalr;
    logic        r_illegal;
    logic        w_accept;

    // A flush frees the slot, so the stage always reports ready during one.
    assign in_ready_o = flush_i || !r_valid || out_ready_i;
    assign w_accept   = in_valid_i && in_ready_o && !flush_i;

    // Valid bit: flush beats accept, accept beats consume.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Payload loads only on an accepted beat and is otherwise held stable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc       <= RESET_PC;
            r_alu_op   <= 5'b0;
            r_src_a    <= 2'b0;
            r_src_b    <= 2'b0;
            r_imm      <= 32'b0;
            r_rs1      <= 5'b0;
            r_rs2      <= 5'b0;
            r_rd       <= 5'b0;
            r_wb_en    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_size <= 3'b0;
            r_branch   <= 1'b0;
            r_jal      <= 1'b0;
            r_jalr     <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_pc       <= pc_i;
            r_alu_op   <= w_alu_op;
            r_src_a    <= w_src_a;
            r_src_b    <= w_src_b;
            r_imm      <= w_imm;
            r_rs1      <= instr_i[19:15];
            r_rs2      <= instr_i[24:20];
            r_rd       <= w_rd;
            r_wb_en    <= w_wb && (w_rd != 5'd0);
            r_mem_req  <= w_mem_req;
            r_mem_we   <= w_mem_we;
            r_mem_size <= w_mem_size;
            r_branch   <= w_branch;
            r_jal      <= w_jal;
            r_jalr     <= w_jalr;
            r_illegal  <= w_illegal;
        end
    end

    assign out_valid_o = r_valid;
    assign pc_o        = r_pc;
    assign alu_op_o    = r_alu_op;
    assign src_a_sel_o = r_src_a;
    assign src_b_sel_o = r_src_b;
    assign imm_o       = r_imm;
    assign rs1_o       = r_rs1;
    assign rs2_o       = r_rs2;
    assign rd_o        = r_rd;
    assign wb_en_o     = r_wb_en;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_size_o  = r_mem_size;
    assign branch_o    = r_branch;
    assign jal_o       = r_jal;
    assign jalr_o      = r_jalr;
    assign illegal_o   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riscv_decode_stage
//  Description : Scoreboard bench for riscv_decode_stage. A driver issues
//                directed and random beats and queues the expected decode;
//                an independent monitor compares whatever the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_decode_stage;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // Named ALU codes as listed for the execute stage.
    localparam logic [4:0] c_ADD = 5'b00000, c_SUB = 5'b01000, c_SLL = 5'b00001,
                           c_LTS = 5'b00010, c_LTU = 5'b00011, c_XOR = 5'b00100,
                           c_SRL = 5'b00101, c_SRA = 5'b01101, c_OR  = 5'b00110,
                           c_AND = 5'b00111, c_EQ  = 5'b11000, c_NE  = 5'b11001,
                           c_LTSF = 5'b11100, c_GES = 5'b11101, c_LTUF = 5'b11110,
                           c_GEU = 5'b11111;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i, pc_i;
    logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
    logic [31:0] pc_o, imm_o;
    logic [4:0]  alu_op_o, rs1_o, rs2_o, rd_o;
    logic [1:0]  src_a_sel_o, src_b_sel_o;
    logic        wb_en_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o, illegal_o;
    logic [2:0]  mem_size_o;

    riscv_decode_stage #(.RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .pc_o(pc_o),
        .alu_op_o(alu_op_o), .src_a_sel_o(src_a_sel_o), .src_b_sel_o(src_b_sel_o),
        .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .wb_en_o(wb_en_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_size_o(mem_size_o),
        .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wb;
        logic        mreq;
        logic        mwe;
        logic [2:0]  msize;
        logic        br;
        logic        jal;
        logic        jalr;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: classify by opcode, look up named ALU codes, apply
    // the legality rules, then strip side effects from illegal beats.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [31:0] imm_u = {ins[31:12], 12'h000};
        logic [31:0] imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bit ok = 1;
        e = '0;
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        if (ins[1:0] != 2'b11) ok = 0;
        else case (opc)
            7'h33: begin
                e.wb = 1;
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                case ({f7[5], f3})
                    4'h0: e.alu = c_ADD;  4'h8: e.alu = c_SUB;  4'h1: e.alu = c_SLL;
                    4'h2: e.alu = c_LTS;  4'h3: e.alu = c_LTU;  4'h4: e.alu = c_XOR;
                    4'h5: e.alu = c_SRL;  4'hD: e.alu = c_SRA;  4'h6: e.alu = c_OR;
                    4'h7: e.alu = c_AND;  default: ok = 0;
                endcase
            end
            7'h13: begin
                e.wb = 1; e.sb = 1; e.imm = imm_i;
                case (f3)
                    3'd0: e.alu = c_ADD; 3'd2: e.alu = c_LTS; 3'd3: e.alu = c_LTU;
                    3'd4: e.alu = c_XOR; 3'd6: e.alu = c_OR;  3'd7: e.alu = c_AND;
                    3'd1: begin e.alu = c_SLL; e.imm = 32'(ins[24:20]); ok = (f7 == 0); end
                    default: begin
                        e.alu = (f7 == 7'h20) ? c_SRA : c_SRL;
                        e.imm = 32'(ins[24:20]);
                        ok = (f7 == 7'h00) || (f7 == 7'h20);
                    end
                endcase
            end
            7'h63: begin
                e.br = 1; e.imm = imm_b;
                case (f3)
                    3'd0: e.alu = c_EQ;   3'd1: e.alu = c_NE;  3'd4: e.alu = c_LTSF;
                    3'd5: e.alu = c_GES;  3'd6: e.alu = c_LTUF; 3'd7: e.alu = c_GEU;
                    default: ok = 0;
                endcase
            end
            7'h03: begin
                e.sb = 1; e.imm = imm_i; e.mreq = 1; e.wb = 1; e.msize = f3;
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
            end
            7'h23: begin
                e.sb = 1; e.imm = imm_s; e.mreq = 1; e.mwe = 1; e.msize = f3;
                ok = (f3 <= 2);
            end
            7'h37: begin e.sa = 2; e.sb = 1; e.imm = imm_u; e.wb = 1; end
            7'h17: begin e.sa = 1; e.sb = 1; e.imm = imm_u; e.wb = 1; end
            7'h6F: begin e.sa = 1; e.sb = 2; e.imm = imm_j; e.wb = 1; e.jal = 1; end
            7'h67: begin e.sa = 1; e.sb = 2; e.imm = imm_i; e.wb = 1; e.jalr = 1; ok = (f3 == 0); end
            7'h0F: ;
            default: ok = 0;
        endcase
        if (e.rd == 0) e.wb = 0;
        if (!ok) begin
            e.alu = c_ADD; e.wb = 0; e.mreq = 0; e.mwe = 0;
            e.br = 0; e.jal = 0; e.jalr = 0; e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37,
                                  7'h17, 7'h6F, 7'h67, 7'h0F, 7'h73};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 12);
        if (k >= 11) return w;
        w[6:0] = opcs[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // One driver cycle: inputs change on the falling edge; the scoreboard is
    // updated at the rising edge from the bench's own view of occupancy.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic rdy, input logic fl);
        bit acc, drop;
        @(negedge clk);
        in_valid_i = v; instr_i = ins; pc_i = p; out_ready_i = rdy; flush_i = fl;
        acc  = v && !fl && ((q.size() == 0) || rdy);
        drop = fl && (q.size() != 0);
        @(posedge clk);
        if (drop) void'(q.pop_front());
        if (acc) q.push_back(model(ins, p));
    endtask

    // Monitor: samples 1 ns before each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_i) begin
                chk("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
                chk("in_ready", 32'(in_ready_o),
                    32'(flush_i || (q.size() == 0) || out_ready_i));
                if (out_valid_o && q.size() != 0) begin
                    e = q[0];
                    chk("pc", pc_o, e.pc);
                    chk("alu_op", 32'(alu_op_o), 32'(e.alu));
                    chk("rs1", 32'(rs1_o), 32'(e.rs1));
                    chk("rs2", 32'(rs2_o), 32'(e.rs2));
                    chk("rd", 32'(rd_o), 32'(e.rd));
                    chk("wb_en", 32'(wb_en_o), 32'(e.wb));
                    chk("mem_req", 32'(mem_req_o), 32'(e.mreq));
                    chk("mem_we", 32'(mem_we_o), 32'(e.mwe));
                    chk("branch", 32'(branch_o), 32'(e.br));
                    chk("jal", 32'(jal_o), 32'(e.jal));
                    chk("jalr", 32'(jalr_o), 32'(e.jalr));
                    chk("illegal", 32'(illegal_o), 32'(e.ill));
                    if (!e.ill) begin
                        chk("src_a", 32'(src_a_sel_o), 32'(e.sa));
                        chk("src_b", 32'(src_b_sel_o), 32'(e.sb));
                        chk("imm", imm_o, e.imm);
                    end
                    if (e.mreq) chk("mem_size", 32'(mem_size_o), 32'(e.msize));
                    if (out_ready_i && !flush_i) begin
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        logic [31:0] pc;
        rst_i = 1'b1; in_valid_i = 0; instr_i = 0; pc_i = 0; out_ready_i = 0; flush_i = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", 32'(out_valid_o), 0);
        chk("reset_pc", pc_o, RESET_PC);
        chk("reset_in_ready", 32'(in_ready_o), 1);
        chk("reset_alu", 32'(alu_op_o), 0);
        chk("reset_imm", imm_o, 0);
        chk("reset_strobes", 32'({wb_en_o, mem_req_o, mem_we_o, branch_o, jal_o, jalr_o, illegal_o}), 0);
        #1 rst_i = 1'b0;

        // Directed decodes from the test plan.
        cycle(1, 32'h002081B3, 32'h100, 1, 0);   // add x3,x1,x2
        cycle(1, 32'h40208133, 32'h104, 1, 0);   // sub
        cycle(1, 32'h4020D093, 32'h108, 1, 0);   // srai
        cycle(1, 32'h0020F463, 32'h10C, 1, 0);   // bgeu
        cycle(1, 32'hFFDFF0EF, 32'h110, 1, 0);   // jal x1,-4
        repeat (3) cycle(1, 32'h002081B3, 32'h114, 0, 0);   // stalled: held, not accepted
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(1, 32'h00000000, 32'h200, 1, 0);   // illegal: low bits 00
        cycle(1, 32'h022081B3, 32'h204, 1, 0);   // illegal: OP funct7=0000001
        cycle(1, 32'h00000073, 32'h208, 1, 0);   // SYSTEM
        cycle(1, 32'h0000000F, 32'h20C, 1, 0);   // FENCE
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Back-to-back stream of eight beats.
        base = popped;
        for (int i = 0; i < 8; i++) cycle(1, rand_instr(), 32'h300 + 32'(i * 4), 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        chk("b2b_count", 32'(popped - base), 8);

        // Flush while holding a beat with a new beat offered.
        cycle(1, 32'h00108093, 32'h400, 0, 0);
        cycle(1, 32'h00210113, 32'h404, 0, 1);
        cycle(0, 32'h0, 32'h0, 1, 0);

        // Asynchronous reset pulse while a beat is held.
        cycle(1, 32'h00308193, 32'h500, 0, 0);
        @(negedge clk);
        in_valid_i = 0;
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid_o), 0);
        chk("rst_async_pc", pc_o, RESET_PC);
        q.delete();
        @(negedge clk);
        #2 rst_i = 1'b0;

        // Randomized traffic.
        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom % 4) != 0, rand_instr(), pc,
                  ($urandom % 4) != 0, ($urandom % 16) == 0);
            pc += 4;
        end
        cycle(0, 32'h0, 32'h0, 1, 0);
        cycle(0, 32'h0, 32'h0, 1, 0);
        chk("final_drain", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
